// File: rtl/grid_render_sequencer_pkg.sv
// Shared constants, colour codes and FSM state type for the grid render sequencer.
package grid_render_sequencer_pkg;

    localparam int unsigned GRID_W  = 160;
    localparam int unsigned GRID_H  = 120;
    localparam int unsigned USER_H  = 4;
    localparam int unsigned ENEMY_H = 4;
    localparam int unsigned GRID_BITS = GRID_W * GRID_H;

    localparam logic [2:0] C_BG    = 3'b000;
    localparam logic [2:0] C_SHOT  = 3'b110;
    localparam logic [2:0] C_USER  = 3'b010;
    localparam logic [2:0] C_ENEMY = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Flat grid bit index for column cx, row cy (max 19199, fits in 15 bits).
    function automatic logic [14:0] grid_index(input logic [7:0] cx, input logic [6:0] cy);
        return 15'(cx) * 15'(GRID_H) + 15'(cy);
    endfunction

endpackage

// File: rtl/grid_render_sequencer_xy_counter.sv
// Raster counter for the scan: row (cy) advances fastest, then column (cx).
module grid_xy_counter
    import grid_render_sequencer_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    output logic [7:0] cx,
    output logic [6:0] cy,
    output logic       last
);

    // Advance y first; at the bottom row wrap y and step to the next column.
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            cx <= '0;
            cy <= '0;
        end else if (enable) begin
            if (cy == 7'(GRID_H - 1)) begin
                cy <= '0;
                cx <= (cx == 8'(GRID_W - 1)) ? '0 : cx + 8'd1;
            end else begin
                cy <= cy + 7'd1;
            end
        end
    end

    // Flags the final pixel of the frame, (GRID_W-1, GRID_H-1).
    always_comb begin
        last = (cx == 8'(GRID_W - 1)) && (cy == 7'(GRID_H - 1));
    end

endmodule

// File: rtl/grid_render_sequencer.sv
// Scans the shot grid out to the VGA write port one pixel per clock, overlays
// player/enemy sprites and reports a per-frame shot/enemy hit.
module grid_render_sequencer
    import grid_render_sequencer_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [GRID_BITS-1:0]   grid,
    input  logic [7:0]             user_x,
    input  logic [7:0]             enemy_x,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   hit,
    output logic [7:0]             hit_count
);

    state_t     state;
    state_t     state_next;
    logic       cnt_clear;
    logic       cnt_en;
    logic [7:0] cx;
    logic [6:0] cy;
    logic       last;
    logic       user_px;
    logic       enemy_px;
    logic       shot_px;
    logic [2:0] pix_colour;
    logic       hit_latch;

    grid_xy_counter u_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .cx      (cx),
        .cy      (cy),
        .last    (last)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and counter control.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SCAN;
                    cnt_clear  = 1'b1;
                end
            end
            ST_SCAN: begin
                cnt_en = 1'b1;
                if (last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pixel classification; an off-screen sprite column simply never matches cx.
    always_comb begin
        user_px  = (cx == user_x) && (cy >= 7'(GRID_H - USER_H));
        enemy_px = (cx == enemy_x) && (cy < 7'(ENEMY_H));
        shot_px  = grid[grid_index(cx, cy)];
        if (user_px) begin
            pix_colour = C_USER;
        end else if (enemy_px) begin
            pix_colour = C_ENEMY;
        end else if (shot_px) begin
            pix_colour = C_SHOT;
        end else begin
            pix_colour = C_BG;
        end
    end

    // Registered VGA port, frame status and hit bookkeeping.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            hit        <= 1'b0;
            hit_count  <= '0;
            hit_latch  <= 1'b0;
        end else begin
            plot       <= 1'b0;
            frame_done <= 1'b0;
            hit        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        hit_latch <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    x      <= cx;
                    y      <= cy;
                    colour <= pix_colour;
                    plot   <= 1'b1;
                    if (enemy_px && shot_px) begin
                        hit_latch <= 1'b1;
                    end
                end
                ST_DONE: begin
                    frame_done <= 1'b1;
                    hit        <= hit_latch;
                    busy       <= 1'b0;
                    if (hit_latch && (hit_count != '1)) begin
                        hit_count <= hit_count + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
